nn_mem_responder: RTL

Memory-side responder for the engine's data/weight memory interface (Mreq/Maddr/Mwrite/Min/Mout). One instance backs the data memory, another the weight memory. It holds 512-bit rows split into 16 independently writable 32-bit lanes and returns read data over a fixed-latency pipeline. After reset it zero-clears its array before accepting requests.

---
 rtl/nn_mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/nn_mem_responder.sv
// Purpose : lane-masked 512-bit row memory answering Mreq with the merged post-write row.
// Latency : response on Mout/Mvalid RD_LAT edges after the request edge; one request per cycle.
// Backpr. : none; Busy is high for DEPTH cycles after reset while rows are zeroed and requests are dropped.
//
// Ports:
//   Clk, Reset (async, active-low)
//   Mreq, Maddr[23:0], Mwrite[15:0] lane mask, Min[511:0]  -> request
//   Mout[511:0], Mvalid                                     -> response (Mout holds between pulses)
//   Busy (clearing), Err (sticky out-of-range address)
module nn_mem_responder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int LANES  = 16,
    parameter int RD_LAT = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Mreq,
    input  logic [23:0]  Maddr,
    input  logic [15:0]  Mwrite,
    input  logic [511:0] Min,
    output logic [511:0] Mout,
    output logic         Mvalid,
    output logic         Busy,
    output logic         Err
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [511:0]      r_mem [0:DEPTH-1];

    // Pipeline stage s holds a response captured s edges after the request edge;
    // the Mout/Mvalid registers form the final stage.
    logic              r_pv [0:RD_LAT-1];
    logic [511:0]      r_pd [0:RD_LAT-1];
    logic [511:0]      r_mout;
    logic              r_mvalid;
    logic              r_err;

    logic              w_acc;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_idx;
    logic [511:0]      w_merged;
    logic [511:0]      w_rsp;

    assign w_acc      = (r_state == ST_READY) && Mreq;
    assign w_in_range = (Maddr[23:ADDR_W] == '0);
    assign w_idx      = Maddr[ADDR_W-1:0];

    // Merged row: masked lanes from Min, the rest from the array as it was before this edge.
    always_comb begin
        w_merged = r_mem[w_idx];
        for (int i = 0; i < LANES; i++) begin
            if (Mwrite[i]) begin
                w_merged[32*i +: 32] = Min[32*i +: 32];
            end
        end
        w_rsp = w_in_range ? w_merged : '0;
    end

    // Array storage has no reset; the INIT sweep zeroes it instead.
    always_ff @(posedge Clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_acc && w_in_range && (Mwrite != '0)) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                r_state <= ST_READY;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int s = 0; s < RD_LAT; s++) begin
                r_pv[s] <= 1'b0;
                r_pd[s] <= '0;
            end
            r_mout   <= '0;
            r_mvalid <= 1'b0;
        end else begin
            r_pv[0] <= w_acc;
            if (w_acc) begin
                r_pd[0] <= w_rsp;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pd[s] <= r_pd[s-1];
            end
            r_mvalid <= r_pv[RD_LAT-1];
            if (r_pv[RD_LAT-1]) begin
                r_mout <= r_pd[RD_LAT-1];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_err <= 1'b0;
        end else if (w_acc && !w_in_range) begin
            r_err <= 1'b1;
        end
    end

    assign Mout   = r_mout;
    assign Mvalid = r_mvalid;
    assign Busy   = (r_state == ST_INIT);
    assign Err    = r_err;

endmodule
